// File: rtl/onehot_decoder_scan_if.sv
// Bus bundle for onehot_decoder_scan: control/index inputs and registered strobe outputs.
// The master drives the controls; the slave (the decoder) drives out, idx and wrap.
interface onehot_decoder_scan_if #(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 8
);
    localparam int OUT_W = 1 << SEL_W;

    logic               en;
    logic               mode;
    logic [SEL_W-1:0]   sel;
    logic               sel_valid;
    logic [DWELL_W-1:0] dwell;
    logic [OUT_W-1:0]   out;
    logic [SEL_W-1:0]   idx;
    logic               wrap;

    modport master (
        output en, mode, sel, sel_valid, dwell,
        input  out, idx, wrap
    );

    modport slave (
        input  en, mode, sel, sel_valid, dwell,
        output out, idx, wrap
    );
endinterface

// File: rtl/onehot_decoder_scan.sv
// Binary-to-one-hot strobe driver with direct decode and autonomous scan modes.
// All outputs are registered; out is always zero or exactly 1 << idx.

module onehot_decoder_scan_chk #(
    parameter int SEL_W = 3
) (
    input logic                      clk,
    input logic                      rst_n,
    input logic [(1 << SEL_W)-1:0]   i_out,
    input logic [SEL_W-1:0]          i_idx,
    input logic                      i_wrap
);
    localparam int OUT_W = 1 << SEL_W;

    // Never more than one strobe active, and it always matches idx.
    a_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        (i_out == {OUT_W{1'b0}}) || (i_out == ({{(OUT_W-1){1'b0}}, 1'b1} << i_idx)));

    a_wrap_at_zero: assert property (@(posedge clk) disable iff (!rst_n)
        i_wrap |-> (i_out[0] && (i_idx == {SEL_W{1'b0}})));
endmodule

module onehot_decoder_scan #(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    onehot_decoder_scan_if.slave bus
);
    localparam int OUT_W = 1 << SEL_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    function automatic logic [OUT_W-1:0] f_onehot(input logic [SEL_W-1:0] i_sel);
        return {{(OUT_W-1){1'b0}}, 1'b1} << i_sel;
    endfunction

    state_t             r_state;
    state_t             w_state_nxt;
    logic [OUT_W-1:0]   r_out;
    logic [OUT_W-1:0]   w_out_nxt;
    logic [SEL_W-1:0]   r_idx;
    logic [SEL_W-1:0]   w_idx_nxt;
    logic               r_wrap;
    logic               w_wrap_nxt;
    logic [DWELL_W-1:0] r_dwell_cnt;
    logic [DWELL_W-1:0] w_dwell_cnt_nxt;
    logic [SEL_W-1:0]   w_idx_inc;

    assign w_idx_inc = r_idx + SEL_W'(1);

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_out       <= {OUT_W{1'b0}};
            r_idx       <= {SEL_W{1'b0}};
            r_wrap      <= 1'b0;
            r_dwell_cnt <= {DWELL_W{1'b0}};
        end else begin
            r_state     <= w_state_nxt;
            r_out       <= w_out_nxt;
            r_idx       <= w_idx_nxt;
            r_wrap      <= w_wrap_nxt;
            r_dwell_cnt <= w_dwell_cnt_nxt;
        end
    end

    // Next-state and next-output decode; en and mode choose the target state every edge.
    always_comb begin
        w_state_nxt     = r_state;
        w_out_nxt       = r_out;
        w_idx_nxt       = r_idx;
        w_wrap_nxt      = 1'b0;
        w_dwell_cnt_nxt = r_dwell_cnt;

        if (!bus.en) begin
            w_state_nxt     = ST_IDLE;
            w_out_nxt       = {OUT_W{1'b0}};
            w_idx_nxt       = {SEL_W{1'b0}};
            w_dwell_cnt_nxt = {DWELL_W{1'b0}};
        end else if (!bus.mode) begin
            w_state_nxt     = ST_DIRECT;
            w_dwell_cnt_nxt = {DWELL_W{1'b0}};
            if (bus.sel_valid) begin
                w_out_nxt = f_onehot(bus.sel);
                w_idx_nxt = bus.sel;
            end else begin
                w_out_nxt = r_out;
                w_idx_nxt = r_idx;
            end
        end else begin
            w_state_nxt = ST_SCAN;
            case (r_state)
                ST_SCAN: begin
                    // Counter is compared for equality only, so a lowered dwell wraps around.
                    if (r_dwell_cnt == bus.dwell) begin
                        w_idx_nxt       = w_idx_inc;
                        w_out_nxt       = f_onehot(w_idx_inc);
                        w_dwell_cnt_nxt = {DWELL_W{1'b0}};
                        w_wrap_nxt      = (r_idx == {SEL_W{1'b1}});
                    end else begin
                        w_dwell_cnt_nxt = r_dwell_cnt + DWELL_W'(1);
                    end
                end
                default: begin
                    w_idx_nxt       = {SEL_W{1'b0}};
                    w_out_nxt       = {{(OUT_W-1){1'b0}}, 1'b1};
                    w_dwell_cnt_nxt = {DWELL_W{1'b0}};
                end
            endcase
        end
    end

    assign bus.out  = r_out;
    assign bus.idx  = r_idx;
    assign bus.wrap = r_wrap;

    onehot_decoder_scan_chk #(.SEL_W(SEL_W)) u_chk (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_out  (r_out),
        .i_idx  (r_idx),
        .i_wrap (r_wrap)
    );
endmodule

// File: tb/tb_onehot_decoder_scan.sv
// Bench for onehot_decoder_scan: an 8-line and a 4-line build share one stimulus stream
// and are compared every cycle against a behavioural model, plus directed literal checks.
module tb_onehot_decoder_scan;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       mode = 1'b0;
    logic [2:0] sel = 3'd0;
    logic       sel_valid = 1'b0;
    logic [7:0] dwell = 8'd0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    onehot_decoder_scan_if #(.SEL_W(3), .DWELL_W(8)) bus8 ();
    onehot_decoder_scan_if #(.SEL_W(2), .DWELL_W(8)) bus4 ();

    assign bus8.en = en;  assign bus8.mode = mode;  assign bus8.sel = sel;
    assign bus8.sel_valid = sel_valid;  assign bus8.dwell = dwell;
    assign bus4.en = en;  assign bus4.mode = mode;  assign bus4.sel = sel[1:0];
    assign bus4.sel_valid = sel_valid;  assign bus4.dwell = dwell;

    onehot_decoder_scan #(.SEL_W(3), .DWELL_W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    onehot_decoder_scan #(.SEL_W(2), .DWELL_W(8)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    // Model: k=0 is the 8-line build, k=1 the 4-line build. st: 0 idle, 1 direct, 2 scan.
    int m_st[2], m_o[2], m_i[2], m_w[2], m_c[2];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic model_step(input int k, input int lines);
        if (!en) begin
            m_st[k] = 0; m_o[k] = 0; m_i[k] = 0; m_c[k] = 0; m_w[k] = 0;
        end else if (!mode) begin
            m_st[k] = 1; m_c[k] = 0; m_w[k] = 0;
            if (sel_valid) begin
                m_i[k] = int'(sel) % lines;
                m_o[k] = 1 << m_i[k];
            end
        end else if (m_st[k] != 2) begin
            m_st[k] = 2; m_i[k] = 0; m_o[k] = 1; m_c[k] = 0; m_w[k] = 0;
        end else if (m_c[k] == int'(dwell)) begin
            m_w[k] = (m_i[k] == lines - 1) ? 1 : 0;
            m_i[k] = (m_i[k] + 1) % lines;
            m_o[k] = 1 << m_i[k];
            m_c[k] = 0;
        end else begin
            m_c[k] = (m_c[k] + 1) % 256;
            m_w[k] = 0;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_st[k] = 0; m_o[k] = 0; m_i[k] = 0; m_w[k] = 0; m_c[k] = 0;
            end
        end else begin
            model_step(0, 8);
            model_step(1, 4);
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("out8",  int'(bus8.out),  m_o[0]);
        chk("idx8",  int'(bus8.idx),  m_i[0]);
        chk("wrap8", int'(bus8.wrap), m_w[0]);
        chk("out4",  int'(bus4.out),  m_o[1]);
        chk("idx4",  int'(bus4.idx),  m_i[1]);
        chk("wrap4", int'(bus4.wrap), m_w[1]);
    end

    task automatic next();
        @(posedge clk);
        #2;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_out", int'(bus8.out), 0);
        chk("rst_idx", int'(bus8.idx), 0);
        chk("rst_wrap", int'(bus8.wrap), 0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        // Direct sweep
        en = 1'b1; mode = 1'b0; sel_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            sel = 3'(k);
            next();
            chk("sweep_out", int'(bus8.out), 1 << k);
            chk("sweep_idx", int'(bus8.idx), k);
            chk("sweep_wrap", int'(bus8.wrap), 0);
        end

        // Hold and qualify
        sel = 3'd5; next();
        sel = 3'd2; sel_valid = 1'b0;
        repeat (4) next();
        chk("hold_out", int'(bus8.out), 32'h20);
        chk("hold_idx", int'(bus8.idx), 5);
        chk("hold_out4", int'(bus4.out), 32'h2);

        // Scan with dwell=2
        en = 1'b0; dwell = 8'd2; next();
        chk("idle_out", int'(bus8.out), 0);
        en = 1'b1; mode = 1'b1; next();
        chk("scan_entry", int'(bus8.out), 32'h01);
        for (int t = 1; t <= 24; t++) begin
            next();
            if (t == 2) chk("scan_d2_hold", int'(bus8.out), 32'h01);
            if (t == 3) chk("scan_d2_adv", int'(bus8.out), 32'h02);
            if (t == 23) chk("scan_d2_nowrap", int'(bus8.wrap), 0);
        end
        chk("sweep24_out", int'(bus8.out), 32'h01);
        chk("sweep24_wrap", int'(bus8.wrap), 1);
        next();
        chk("wrap_pulse_end", int'(bus8.wrap), 0);

        // Scan with dwell=0; the 4-line build wraps every 4 cycles
        en = 1'b0; dwell = 8'd0; next();
        en = 1'b1; next();
        repeat (3) next();
        chk("d0_out8", int'(bus8.out), 32'h08);
        chk("d0_out4", int'(bus4.out), 32'h8);
        next();
        chk("d0_out4_wrap", int'(bus4.out), 32'h1);
        chk("d0_wrap4", int'(bus4.wrap), 1);
        chk("d0_out8_b", int'(bus8.out), 32'h10);

        // Disable mid-scan at idx=3, re-enable, then switch to direct
        en = 1'b0; next();
        en = 1'b1; next();
        repeat (3) next();
        chk("ms_idx3", int'(bus8.idx), 3);
        en = 1'b0; next();
        chk("dis_out", int'(bus8.out), 0);
        en = 1'b1; next();
        chk("reen_out", int'(bus8.out), 32'h01);
        mode = 1'b0; sel_valid = 1'b0; sel = 3'd6;
        repeat (2) next();
        chk("dir_hold_out", int'(bus8.out), 32'h01);
        sel_valid = 1'b1; next();
        chk("dir_sel6_out", int'(bus8.out), 32'h40);
        chk("dir_sel6_idx", int'(bus8.idx), 6);

        // Async reset mid-scan
        mode = 1'b1; sel_valid = 1'b0;
        repeat (3) next();
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out", int'(bus8.out), 0);
        chk("arst_idx", int'(bus8.idx), 0);
        chk("arst_wrap", int'(bus8.wrap), 0);
        repeat (2) @(posedge clk);
        #2;
        chk("arst_hold_out", int'(bus8.out), 0);
        rst_n = 1'b1;
        next();
        chk("post_rst_entry", int'(bus8.out), 32'h01);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            en = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 14) == 0) mode = ~mode;
            sel = 3'($urandom);
            sel_valid = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0)
                dwell = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
            next();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
